ws_pe_driver: RTL and testbench
===============================

# ws_pe_driver

Sequencer that drives one weight-stationary PE column (ROWS stacked WS_PE instances; outp of row r feeds psum of row r+1).
- Accepts a configuration stream of ROWS weights followed by one bias, and writes each weight into its PE with a per-row strobe.
- Streams activation vectors into the column with per-row skew, so each partial sum meets its row's input on the correct step.
- Flushes the pipeline with zero inputs and signals completion.
- Sits between the line buffers and the PE array, as the producer side of the PE xin/win/psum/load_w/enable interface.

## Interface
- ROWS, 3: PEs in the column (1..16).
- DW, 8: data width, Q1.6 signed.
- sys_clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a pass; sampled only in IDLE.
- n_cols  in  8  activation beats in the pass; latched on start.
- cfg_valid / cfg_ready  in / out  1 / 1  config handshake; a beat transfers when both are high.
- cfg_data  in  DW  weight beats for rows 0..ROWS-1, then the bias beat.
- x_valid / x_ready  in / out  1 / 1  activation handshake.
- x_data  in  ROWS*DW  one activation per row; row r occupies [r*DW +: DW].
- pe_win  out  DW  shared weight bus.
- pe_load_w  out  ROWS  one-hot weight strobe; bit r goes to PE r.
- pe_xin  out  ROWS*DW  skewed activations; row r goes to PE r.
- pe_psum  out  DW  bias into row 0 psum.
- pe_enable  out  1  column enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse.

## Operation
- States: IDLE, LOADW, LOADB, STREAM, FLUSH, DONE.
- IDLE
  - start=1: latch n_cols, clear the weight index and beat counter, go to LOADW.
  - start while busy is ignored.
- LOADW
  - cfg_ready=1 only when no strobe is in progress.
  - On accepting weight i: pe_win<=cfg_data.
  - Next cycle: pe_load_w=1<<i for exactly one cycle; cfg_ready=0 during that cycle.
  - After the strobe for i=ROWS-1, go to LOADB.
- LOADB
  - cfg_ready=1.
  - On accept: pe_psum<=cfg_data, then go to STREAM, or to FLUSH if n_cols==0.
- Hold rules
  - pe_win holds its value until the next weight is accepted. The PE latches the weight on any load_w change, so win must be stable around the strobe.
  - pe_psum holds the bias until the next LOADB accept.
- STREAM
  - x_ready=1.
  - On an accepted beat (a step):
    - row-0 register <= x_data row 0;
    - each row r>0 shifts an r-stage delay line, injecting x_data row r;
    - pe_enable<=1;
    - the beat counter increments.
  - On a non-accepted cycle: pe_enable<=0 and all skew registers hold. The PEs freeze, so stalls are lossless.
  - After beat n_cols is accepted, go to FLUSH, or to DONE if ROWS==1.
- FLUSH
  - x_ready=0.
  - Runs ROWS-1 steps, each with pe_enable<=1 and zeros injected into all rows. A PE passes psum through on xin==0.
  - Then go to DONE.
- DONE
  - done=1 for one cycle, pe_enable<=0, then go to IDLE.
- Arithmetic: none; data is passed bit-exact. Outputs are registered except cfg_ready, x_ready and busy, which decode from state.
- Reset
  - Reset forces IDLE, including mid-pass.
  - All registered outputs and skew registers go to 0; pe_load_w=0.
  - Reset does not clear weights already latched in the PEs; the next pass reloads them.

## Timing
- Reset values: cfg_ready=0, x_ready=0, busy=0, done=0, pe_enable=0, pe_load_w=0, pe_win=0, pe_xin=0, pe_psum=0.
- start sampled at cycle 0: LOADW and cfg_ready=1 from cycle 1.
- Each weight costs at least 2 cycles (accept, then strobe). Full config with no cfg stalls is 2*ROWS+1 cycles.
- Beat k (0-based) accepted at edge e: row r's element appears on pe_xin at the edge that completes step k+r, always together with pe_enable=1.
- Back-to-back beats: one step per cycle.
- With no stalls, done pulses n_cols+ROWS-1 cycles after the first beat acceptance, plus 1.
- cfg_valid in STREAM/FLUSH and x_valid outside STREAM are ignored (ready is low).

## Test plan
- Weight load, ROWS=3, cfg 0x20,0x40,0xE0,0x10:
  - pe_load_w pulses 001, 010, 100 on alternate cycles;
  - pe_win equals the matching weight during and one cycle around each strobe;
  - pe_psum=0x10 after the bias beat.
- Skew, n_cols=2, beats {r0=1,r1=2,r2=3} and {4,5,6}, no stalls. Per step, (row0, row1, row2):
  - step 0: (1, 0, 0)
  - step 1: (4, 2, 0)
  - step 2: (0, 5, 3)
  - step 3: (0, 0, 6)
  - pe_enable high on all 4 steps; done 1 cycle later.
- Stall: x_valid low for 3 cycles between beats:
  - pe_enable low for exactly those 3 cycles;
  - pe_xin unchanged across the gap;
  - step sequence identical to the skew case.
- n_cols=0: after the bias, 2 flush steps of zeros, then done; x_ready never asserted.
- Reset asserted mid-STREAM: all outputs 0 the same cycle; busy=0; a following start reloads weights from LOADW.
- start pulsed during LOADW and STREAM: no effect; exactly one done per accepted start.

Source files
------------

// File: rtl/ws_pe_driver_if.sv
// Handshake and PE-facing bus bundle for the weight-stationary column driver.
// master = driver side (consumes cfg/x streams, produces PE controls); slave = its peer.
interface ws_pe_driver_if #(
  parameter int ROWS = 3,
  parameter int DW   = 8
);
  logic                 start;
  logic [7:0]           n_cols;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [DW-1:0]        cfg_data;
  logic                 x_valid;
  logic                 x_ready;
  logic [ROWS*DW-1:0]   x_data;
  logic [DW-1:0]        pe_win;
  logic [ROWS-1:0]      pe_load_w;
  logic [ROWS*DW-1:0]   pe_xin;
  logic [DW-1:0]        pe_psum;
  logic                 pe_enable;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, n_cols, cfg_valid, cfg_data, x_valid, x_data,
    output cfg_ready, x_ready, pe_win, pe_load_w, pe_xin, pe_psum, pe_enable, busy, done
  );

  modport slave (
    output start, n_cols, cfg_valid, cfg_data, x_valid, x_data,
    input  cfg_ready, x_ready, pe_win, pe_load_w, pe_xin, pe_psum, pe_enable, busy, done
  );
endinterface

// File: rtl/ws_pe_driver.sv
// Sequencer for one WS PE column: weight/bias load, skewed activation streaming, zero flush.
// Latency: 2 cycles/weight + 1 bias; one step per accepted beat; x stalls freeze the column losslessly.
module ws_pe_driver #(
  parameter int ROWS = 3,
  parameter int DW   = 8
) (
  input  logic          sys_clk,
  input  logic          rst,
  ws_pe_driver_if.master bus
);

  typedef enum logic [2:0] {IDLE, LOADW, LOADB, STREAM, FLUSH, DONE} state_t;

  localparam int            IW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [IW-1:0] W_LAST = IW'(ROWS - 1);
  localparam logic [7:0]    F_LAST = (ROWS > 1) ? 8'(ROWS - 2) : 8'd0;

  state_t             state;
  logic [IW-1:0]      widx;
  logic [7:0]         cnt;
  logic [7:0]         ncols_q;
  logic [DW-1:0]      win_q;
  logic [DW-1:0]      psum_q;
  logic [ROWS-1:0]    load_q;
  logic               en_q;
  logic               done_q;
  logic [ROWS*DW-1:0] xin_w;

  logic cfg_rdy;
  logic x_rdy;
  logic step;

  // A pending strobe blocks the next weight so pe_win stays stable around load_w.
  assign cfg_rdy = ((state == LOADW) && (load_q == '0)) || (state == LOADB);
  assign x_rdy   = (state == STREAM);
  assign step    = ((state == STREAM) && bus.x_valid) || (state == FLUSH);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      widx    <= '0;
      cnt     <= '0;
      ncols_q <= '0;
      win_q   <= '0;
      psum_q  <= '0;
      load_q  <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            ncols_q <= bus.n_cols;
            widx    <= '0;
            cnt     <= '0;
            state   <= LOADW;
          end
        end
        LOADW: begin
          if (bus.cfg_valid && cfg_rdy) begin
            win_q  <= bus.cfg_data;
            load_q <= ROWS'(1) << widx;
          end else if (load_q != '0) begin
            load_q <= '0;
            if (widx == W_LAST) state <= LOADB;
            else                widx  <= widx + 1'b1;
          end
        end
        LOADB: begin
          if (bus.cfg_valid) begin
            psum_q <= bus.cfg_data;
            cnt    <= '0;
            if (ncols_q == 8'd0) state <= (ROWS == 1) ? DONE : FLUSH;
            else                 state <= STREAM;
          end
        end
        STREAM: begin
          if (bus.x_valid) begin
            en_q <= 1'b1;
            if (cnt + 8'd1 == ncols_q) begin
              cnt   <= '0;
              state <= (ROWS == 1) ? DONE : FLUSH;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        FLUSH: begin
          en_q <= 1'b1;
          cnt  <= cnt + 8'd1;
          if (cnt == F_LAST) state <= DONE;
        end
        DONE: begin
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Row r uses r+1 registers so beat k reaches PE r on step k+r.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DW-1:0] dl [r+1];

    always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j <= r; j++) dl[j] <= '0;
      end else if (step) begin
        dl[0] <= (state == FLUSH) ? '0 : bus.x_data[r*DW +: DW];
        for (int j = 1; j <= r; j++) dl[j] <= dl[j-1];
      end
    end

    assign xin_w[r*DW +: DW] = dl[r];
  end

  assign bus.cfg_ready = cfg_rdy;
  assign bus.x_ready   = x_rdy;
  assign bus.busy      = (state != IDLE);
  assign bus.pe_win    = win_q;
  assign bus.pe_load_w = load_q;
  assign bus.pe_xin    = xin_w;
  assign bus.pe_psum   = psum_q;
  assign bus.pe_enable = en_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ws_pe_driver.sv
// Directed bench for ws_pe_driver (ROWS=3, DW=8): weight load, skew, stall, empty pass, mid-pass reset.
module tb_ws_pe_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  ws_pe_driver_if #(.ROWS(3), .DW(8)) bus ();

  ws_pe_driver #(.ROWS(3), .DW(8)) dut (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_pass(input logic [7:0] n);
    bus.n_cols = n;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.n_cols = 8'd77;
    chk("busy_loadw", bus.busy, 1);
    chk("cfg_ready_loadw", bus.cfg_ready, 1);
  endtask

  task automatic load_cfg(input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input logic [7:0] b);
    logic [7:0] w [3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    for (int i = 0; i < 3; i++) begin
      chk("cfg_ready_w", bus.cfg_ready, 1);
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = w[i];
      tick();
      chk("strobe", bus.pe_load_w, 32'(1 << i));
      chk("win_strobe", bus.pe_win, w[i]);
      chk("cfg_ready_strobe", bus.cfg_ready, 0);
      bus.cfg_data = 8'hA5;
      tick();
      chk("strobe_clear", bus.pe_load_w, 0);
      chk("win_hold", bus.pe_win, w[i]);
    end
    chk("cfg_ready_loadb", bus.cfg_ready, 1);
    bus.cfg_data = b;
    tick();
    bus.cfg_valid = 1'b0;
    chk("psum_bias", bus.pe_psum, b);
    chk("win_after_bias", bus.pe_win, w2);
    chk("cfg_ready_after", bus.cfg_ready, 0);
  endtask

  task automatic step_chk(input string tag, input logic [23:0] xin, input logic en);
    tick();
    chk(tag, bus.pe_xin, xin);
    chk("enable", bus.pe_enable, en);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.n_cols    = 8'd0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = 8'd0;
    bus.x_valid   = 1'b0;
    bus.x_data    = 24'd0;
    tick();
    tick();
    chk("rst_cfg_ready", bus.cfg_ready, 0);
    chk("rst_x_ready", bus.x_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_enable", bus.pe_enable, 0);
    chk("rst_load_w", bus.pe_load_w, 0);
    chk("rst_win", bus.pe_win, 0);
    chk("rst_xin", bus.pe_xin, 0);
    chk("rst_psum", bus.pe_psum, 0);
    rst = 1'b0;
    tick();

    // Pass 1: weight load with a stray start, then the basic skew pattern.
    begin_pass(8'd2);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_in_loadw_ignored", bus.pe_load_w, 0);
    chk("still_loadw", bus.cfg_ready, 1);
    load_cfg(8'h20, 8'h40, 8'hE0, 8'h10);
    chk("x_ready_stream", bus.x_ready, 1);
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = 8'h55;
    bus.x_valid   = 1'b1;
    bus.x_data    = 24'h030201;
    step_chk("p1_step0", 24'h000001, 1'b1);
    bus.x_data    = 24'h060504;
    step_chk("p1_step1", 24'h000204, 1'b1);
    chk("x_ready_flush", bus.x_ready, 0);
    bus.x_valid   = 1'b0;
    step_chk("p1_step2", 24'h030500, 1'b1);
    step_chk("p1_step3", 24'h060000, 1'b1);
    chk("p1_done_early", bus.done, 0);
    chk("p1_busy_last", bus.busy, 1);
    tick();
    chk("p1_done", bus.done, 1);
    chk("p1_enable_done", bus.pe_enable, 0);
    chk("p1_busy_done", bus.busy, 0);
    chk("p1_psum_kept", bus.pe_psum, 8'h10);
    chk("p1_win_kept", bus.pe_win, 8'hE0);
    bus.cfg_valid = 1'b0;
    tick();
    chk("p1_done_pulse", bus.done, 0);

    // Pass 2: 3-cycle x stall between beats, with a stray start in the gap.
    begin_pass(8'd2);
    load_cfg(8'h7F, 8'h01, 8'h80, 8'hF0);
    bus.x_valid = 1'b1;
    bus.x_data  = 24'h030201;
    step_chk("p2_step0", 24'h000001, 1'b1);
    bus.x_valid = 1'b0;
    bus.x_data  = 24'hFFFFFF;
    for (int g = 0; g < 3; g++) begin
      bus.start = (g == 0);
      step_chk("p2_stall_xin", 24'h000001, 1'b0);
      chk("p2_stall_x_ready", bus.x_ready, 1);
    end
    bus.start   = 1'b0;
    bus.x_valid = 1'b1;
    bus.x_data  = 24'h060504;
    step_chk("p2_step1", 24'h000204, 1'b1);
    bus.x_valid = 1'b0;
    step_chk("p2_step2", 24'h030500, 1'b1);
    step_chk("p2_step3", 24'h060000, 1'b1);
    tick();
    chk("p2_done", bus.done, 1);

    // Pass 3: n_cols=0 goes straight to flush; activations offered but never taken.
    begin_pass(8'd0);
    load_cfg(8'h11, 8'h22, 8'h33, 8'h44);
    chk("p3_x_ready_0", bus.x_ready, 0);
    chk("p3_enable_0", bus.pe_enable, 0);
    bus.x_valid = 1'b1;
    bus.x_data  = 24'h123456;
    step_chk("p3_flush0", 24'h000000, 1'b1);
    chk("p3_x_ready_1", bus.x_ready, 0);
    step_chk("p3_flush1", 24'h000000, 1'b1);
    chk("p3_x_ready_2", bus.x_ready, 0);
    tick();
    chk("p3_done", bus.done, 1);
    chk("p3_enable_done", bus.pe_enable, 0);
    bus.x_valid = 1'b0;

    // Pass 4: reset mid-stream, then a fresh pass reloads from LOADW.
    begin_pass(8'd2);
    load_cfg(8'h05, 8'h06, 8'h07, 8'h08);
    bus.x_valid = 1'b1;
    bus.x_data  = 24'h030201;
    step_chk("p4_step0", 24'h000001, 1'b1);
    bus.x_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_enable", bus.pe_enable, 0);
    chk("rst_mid_xin", bus.pe_xin, 0);
    chk("rst_mid_psum", bus.pe_psum, 0);
    chk("rst_mid_win", bus.pe_win, 0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_x_ready", bus.x_ready, 0);
    #2;
    rst = 1'b0;
    tick();
    chk("post_rst_idle", bus.busy, 0);
    begin_pass(8'd1);
    load_cfg(8'h09, 8'h0A, 8'h0B, 8'h0C);
    bus.x_valid = 1'b1;
    bus.x_data  = 24'h090807;
    step_chk("p5_step0", 24'h000007, 1'b1);
    bus.x_valid = 1'b0;
    step_chk("p5_step1", 24'h000800, 1'b1);
    step_chk("p5_step2", 24'h090000, 1'b1);
    tick();
    chk("p5_done", bus.done, 1);
    tick();
    chk("done_count", done_cnt, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
